// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns a valid/ready command into one SETUP/ACCESS transfer and
// returns a single-cycle response carrying read data, slave error and timeout status.
module apb_master_bridge #(
    parameter int unsigned APB_AWIDTH     = 20,
    parameter int unsigned APB_DWIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_AWIDTH-1:0] cmd_addr,
    input  logic [APB_DWIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [APB_DWIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_AWIDTH-1:0] PADDR,
    output logic [APB_DWIDTH-1:0] PWDATA,
    input  logic [APB_DWIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    // Encoding chosen so bit 0 is PSEL and bit 1 is PENABLE: both are glitch-free flop outputs
    // and SETUP->ACCESS only raises PENABLE.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_AWIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DWIDTH-1:0] pwdata_q, pwdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [APB_DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d  = StSetup;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    cnt_d    = '0;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    state_d       = StIdle;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
                    state_d       = StIdle;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= StIdle;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign PSEL        = state_q[0];
    assign PENABLE     = state_q[1];
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus randomized transfers, each checked
// cycle by cycle against the expected APB phase sequence and response.
module tb_apb_master_bridge;

    localparam int TO = 8;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [19:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [19:0] PADDR;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_pass;
    int n_total;

    // Last response the bench expects the DUT to be holding.
    logic [15:0] last_rd;
    logic        last_err;
    logic        last_to;

    apb_master_bridge #(
        .APB_AWIDTH    (20),
        .APB_DWIDTH    (16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            PREADY    = 1'($urandom);
            PSLVERR   = 1'($urandom);
            tick();
            check("idle_rspv", 32'(rsp_valid), 32'd0);
            check("idle_psel", 32'(PSEL), 32'd0);
            check("idle_ready", 32'(cmd_ready), 32'd1);
        end
    endtask

    // Caller is in an IDLE cycle; returns in the response cycle (which is IDLE again).
    // waits >= TO means the completer never answers and the bridge must time out.
    task automatic xfer(input bit wr, input logic [19:0] a, input logic [15:0] d,
                        input int waits, input logic [15:0] rd, input bit err);
        bit          to;
        int          n_acc;
        bit          rdy;
        logic [15:0] exp_rd;
        to    = (waits >= TO);
        n_acc = to ? TO : waits + 1;

        check("accept_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        PREADY    = 1'($urandom);
        PSLVERR   = 1'($urandom);
        tick();

        check("setup_psel", 32'(PSEL), 32'd1);
        check("setup_penable", 32'(PENABLE), 32'd0);
        check("setup_paddr", 32'(PADDR), 32'(a));
        check("setup_pwdata", 32'(PWDATA), 32'(d));
        check("setup_pwrite", 32'(PWRITE), 32'(wr));
        check("setup_ready", 32'(cmd_ready), 32'd0);
        check("setup_rspv", 32'(rsp_valid), 32'd0);
        check("hold_rdata", 32'(rsp_rdata), 32'(last_rd));
        check("hold_err", 32'(rsp_err), 32'(last_err));
        check("hold_timeout", 32'(rsp_timeout), 32'(last_to));
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = 20'($urandom);
        cmd_wdata = 16'($urandom);
        PSLVERR   = 1'b1;
        PREADY    = 1'($urandom);
        tick();

        for (int i = 0; i < n_acc; i++) begin
            check("access_psel", 32'(PSEL), 32'd1);
            check("access_penable", 32'(PENABLE), 32'd1);
            check("access_paddr", 32'(PADDR), 32'(a));
            check("access_pwdata", 32'(PWDATA), 32'(d));
            check("access_pwrite", 32'(PWRITE), 32'(wr));
            check("access_ready", 32'(cmd_ready), 32'd0);
            check("access_rspv", 32'(rsp_valid), 32'd0);
            rdy       = !to && (i == waits);
            PREADY    = rdy;
            PRDATA    = rdy ? rd : 16'($urandom);
            PSLVERR   = rdy ? err : 1'($urandom);
            cmd_valid = 1'($urandom);
            cmd_addr  = 20'($urandom);
            tick();
        end

        exp_rd   = (to || wr) ? 16'h0 : rd;
        last_rd  = exp_rd;
        last_err = to ? 1'b1 : err;
        last_to  = to;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check("rsp_err", 32'(rsp_err), 32'(last_err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(last_to));
        check("rsp_psel", 32'(PSEL), 32'd0);
        check("rsp_penable", 32'(PENABLE), 32'd0);
        check("rsp_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        last_rd   = '0;
        last_err  = 1'b0;
        last_to   = 1'b0;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        #2;
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_pwdata", 32'(PWDATA), 32'd0);
        check("rst_rspv", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_timeout", 32'(rsp_timeout), 32'd0);
        tick();
        tick();
        PRESET = 1'b0;
        #1;
        check("rst_release_ready", 32'(cmd_ready), 32'd1);
        idle(1);

        // Zero-wait write, 3-wait read, slave error, timeout, then recovery.
        xfer(1'b1, 20'h00010, 16'hA5C3, 0, 16'h0, 1'b0);
        idle(1);
        xfer(1'b0, 20'h00020, 16'h0, 3, 16'h1234, 1'b0);
        idle(2);
        xfer(1'b0, 20'h00030, 16'h0, 0, 16'hBEEF, 1'b1);
        xfer(1'b0, 20'h00040, 16'h0, 1, 16'h5A5A, 1'b0);
        idle(1);
        xfer(1'b0, 20'h00050, 16'h0, TO + 5, 16'hFFFF, 1'b0);
        xfer(1'b0, 20'h00060, 16'h0, 0, 16'h0F0F, 1'b0);

        // Back-to-back, one accept every third cycle.
        for (int k = 0; k < 4; k++) begin
            xfer(1'b1, 20'(2 * k), 16'($urandom), 0, 16'h0, 1'b0);
        end
        idle(1);

        for (int k = 0; k < 40; k++) begin
            int w;
            w = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, 3));
            xfer(1'($urandom), 20'($urandom), 16'($urandom), w, 16'($urandom),
                 ($urandom_range(0, 3) == 0));
            idle(int'($urandom_range(0, 2)));
        end

        // Reset while in ACCESS.
        idle(1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 20'h0ABCD;
        cmd_wdata = 16'h1111;
        PREADY    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_penable", 32'(PENABLE), 32'd1);
        #2;
        PRESET = 1'b1;
        #1;
        check("mid_rst_psel", 32'(PSEL), 32'd0);
        check("mid_rst_penable", 32'(PENABLE), 32'd0);
        check("mid_rst_rspv", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        PRESET   = 1'b0;
        last_rd  = '0;
        last_err = 1'b0;
        last_to  = 1'b0;
        tick();
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_rspv", 32'(rsp_valid), 32'd0);
        check("post_rst_psel", 32'(PSEL), 32'd0);
        xfer(1'b0, 20'h00070, 16'h0, 2, 16'hC0DE, 1'b0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB3 initiator that converts a simple valid/ready command interface into single APB transfers.
- It drives the completer side of the team's APB-attached peripherals, e.g. the 16-bit-wide, 20-bit-addressed LSRAM store.
- It handles PREADY wait states and PSLVERR, and aborts with a timeout if a completer hangs.

Parameters:
APB_AWIDTH, 20, width of PADDR and cmd_addr
APB_DWIDTH, 16, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
TIMEOUT_CYCLES, 256, max ACCESS-phase cycles with PREADY low before abort; 0 disables timeout

Ports:
PCLK  in  1  clock; all logic rising-edge
PRESET  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  bridge can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  APB_AWIDTH  transfer address
cmd_wdata  in  APB_DWIDTH  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  APB_DWIDTH  read data (0 for writes/timeouts)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  APB_AWIDTH  APB address
PWDATA  out  APB_DWIDTH  APB write data
PRDATA  in  APB_DWIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (asynchronous on PRESET high):
  - State IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, timeout counter all 0.
  - cmd_ready=1 once PRESET deasserts.
- States:
  - IDLE: cmd_ready=1. The command is accepted on the cycle with cmd_valid & cmd_ready. The bridge registers cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and moves to SETUP.
  - SETUP: PSEL=1, PENABLE=0, cmd_ready=0. Unconditional move to ACCESS next cycle.
  - ACCESS: PSEL=1, PENABLE=1, cmd_ready=0.
    - On a cycle sampling PREADY=1: capture PRDATA (reads only; writes capture 0) into rsp_rdata, rsp_err<=PSLVERR, rsp_timeout<=0, rsp_valid<=1. Move to IDLE; PSEL/PENABLE drop next cycle.
    - On a cycle sampling PREADY=0: increment the wait counter.
    - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 while PREADY=0: abort. rsp_valid<=1, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0. Move to IDLE.
- Timeout counter:
  - Cleared on entry to SETUP.
  - Width is clog2(TIMEOUT_CYCLES+1), minimum 1.
  - It never wraps; it saturates when TIMEOUT_CYCLES=0.
- PSLVERR is sampled only in ACCESS with PREADY=1 and is ignored at all other times.
- PWRITE/PADDR/PWDATA stay stable from SETUP through the last ACCESS cycle. They hold their last value in IDLE and change only on command acceptance.
- rsp_valid is high exactly one cycle. rsp_rdata/err/timeout hold until the next response.
- Latency, zero-wait completer:
  - Accept in cycle N, SETUP N+1, ACCESS N+2 (PREADY=1), rsp_valid and cmd_ready both high in N+3.
  - A new command can be accepted in N+3, so back-to-back throughput is 3 cycles per transfer.
  - Each PREADY-low cycle adds exactly one cycle.
- No response backpressure: the consumer must take rsp_valid when it pulses.
- cmd_valid while cmd_ready=0 is ignored, not queued. Command inputs are don't-care outside acceptance.
- Reset mid-transfer: PSEL/PENABLE fall asynchronously and no rsp_valid is issued for the aborted transfer.
- PSEL and PENABLE never both toggle low-to-high in the same cycle. PENABLE=1 implies PSEL=1.

Test Plan:
- Write, PREADY tied 1: cmd addr=0x00010, wdata=0xA5C3 accepted at N.
  - PSEL=1/PENABLE=0 at N+1, PENABLE=1 at N+2, PADDR=0x00010, PWDATA=0xA5C3, PWRITE=1.
  - rsp_valid=1, rsp_err=0, rsp_rdata=0 at N+3.
- Read with 3 wait states: PREADY low for 3 ACCESS cycles, PRDATA=0x1234 on the ready cycle.
  - rsp_valid at N+6, rsp_rdata=0x1234.
  - PADDR stable throughout the transfer.
- Slave error: read completes with PREADY=1, PSLVERR=1 → rsp_err=1, rsp_timeout=0.
  - PSLVERR=1 during SETUP alone must not set rsp_err.
- Timeout, TIMEOUT_CYCLES=8, PREADY stuck 0:
  - Exactly 8 ACCESS cycles, then PSEL=0.
  - rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The next command completes normally.
- Back-to-back: cmd_valid held high with 4 commands, zero-wait completer.
  - Accepts every 3 cycles, 4 rsp_valid pulses, correct address order 0x0,0x2,0x4,0x6.
- Reset mid-ACCESS: assert PRESET while PENABLE=1.
  - PSEL/PENABLE go 0 asynchronously (same timestep), no rsp_valid.
  - cmd_ready=1 on the first clock after release.
